// File: rtl/sm83_reg_sp_in.sv
// SM83 stack pointer, load side: byte loads from the precharged data bus,
// full loads from the IDU, push/pop stepping, and LD SP,nn pair tracking.
module sm83_reg_sp_in #(
  parameter logic [15:0] RESET_VAL  = 16'h0000,
  parameter int unsigned L_sp       = 60,
  parameter real         T_setup_ns = 0.5
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [7:0]  bus,
  input  logic [15:0] idu,
  input  logic        ld_lo,
  input  logic        ld_hi,
  input  logic        ld_idu,
  input  logic        inc,
  input  logic        dec,
  output logic [15:0] sp,
  output logic        lo_pending,
  output logic        pair_done,
  output logic        ctl_err
);

  typedef enum logic [0:0] {
    ST_IDLE    = 1'b0,
    ST_LO_HELD = 1'b1
  } state_t;

  // Elmore-style clk-to-sp estimates: intrinsic flop delay plus driver R times load C.
  function automatic int unsigned elmore_rise_ps(input int unsigned load);
    return 32'd35 + (load * 32'd3);
  endfunction

  function automatic int unsigned elmore_fall_ps(input int unsigned load);
    return 32'd30 + (load * 32'd2);
  endfunction

  localparam int unsigned CLK_TO_SP_PS =
    (elmore_rise_ps(L_sp) > elmore_fall_ps(L_sp)) ? elmore_rise_ps(L_sp) : elmore_fall_ps(L_sp);

  // A negative setup window or a clk-to-sp delay beyond one half-cycle of the
  // slowest supported clock means the timing model was mis-parameterised.
  if ((T_setup_ns < 0.0) || (CLK_TO_SP_PS > 32'd5000)) begin : g_timing_param_check
    $error("sm83_reg_sp_in: timing parameters out of range");
  end

  state_t      state_r;
  logic [15:0] sp_r;
  logic        lo_pending_r;
  logic        pair_done_r;
  logic        ctl_err_r;

  logic [7:0]  bus_s;
  logic        byte_ld_s;
  logic        illegal_s;
  logic [15:0] sp_nxt_s;

  // Precharged bus: anything not actively pulled low reads as 1.
  always_comb begin
    bus_s = 8'hFF;
    for (int i = 0; i < 8; i++) begin
      if (bus[i] === 1'b0) begin
        bus_s[i] = 1'b0;
      end else begin
        bus_s[i] = 1'b1;
      end
    end
  end

  // Control decode: which operations collide on this edge.
  always_comb begin
    byte_ld_s = ld_lo | ld_hi;
    illegal_s = (ld_idu & (ld_lo | ld_hi | inc | dec))
              | (byte_ld_s & (inc | dec))
              | (inc & dec);
  end

  // Next SP with priority ld_idu > byte loads > inc/dec > hold.
  always_comb begin
    sp_nxt_s = sp_r;
    if (ld_idu) begin
      sp_nxt_s = idu;
    end else if (byte_ld_s) begin
      sp_nxt_s[7:0]  = ld_lo ? bus_s : sp_r[7:0];
      sp_nxt_s[15:8] = ld_hi ? bus_s : sp_r[15:8];
    end else if (inc && !dec) begin
      sp_nxt_s = sp_r + 16'd1;
    end else if (dec && !inc) begin
      sp_nxt_s = sp_r - 16'd1;
    end else begin
      sp_nxt_s = sp_r;
    end
  end

  // SP register and sticky control-error flag.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sp_r      <= RESET_VAL;
      ctl_err_r <= 1'b0;
    end else begin
      sp_r      <= sp_nxt_s;
      ctl_err_r <= ctl_err_r | illegal_s;
    end
  end

  // Pair-load FSM; ld_idu masks byte loads, so it never completes a pair.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r      <= ST_IDLE;
      lo_pending_r <= 1'b0;
      pair_done_r  <= 1'b0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (ld_idu) begin
            state_r      <= ST_IDLE;
            lo_pending_r <= 1'b0;
            pair_done_r  <= 1'b0;
          end else if (ld_lo && ld_hi) begin
            state_r      <= ST_IDLE;
            lo_pending_r <= 1'b0;
            pair_done_r  <= 1'b1;
          end else if (ld_lo) begin
            state_r      <= ST_LO_HELD;
            lo_pending_r <= 1'b1;
            pair_done_r  <= 1'b0;
          end else begin
            state_r      <= ST_IDLE;
            lo_pending_r <= 1'b0;
            pair_done_r  <= 1'b0;
          end
        end
        ST_LO_HELD: begin
          if (ld_idu) begin
            state_r      <= ST_IDLE;
            lo_pending_r <= 1'b0;
            pair_done_r  <= 1'b0;
          end else if (ld_hi) begin
            state_r      <= ST_IDLE;
            lo_pending_r <= 1'b0;
            pair_done_r  <= 1'b1;
          end else if (ld_lo) begin
            state_r      <= ST_LO_HELD;
            lo_pending_r <= 1'b1;
            pair_done_r  <= 1'b0;
          end else if (inc || dec) begin
            // Stack op interrupts the pair; the op itself still runs.
            state_r      <= ST_IDLE;
            lo_pending_r <= 1'b0;
            pair_done_r  <= 1'b0;
          end else begin
            state_r      <= ST_LO_HELD;
            lo_pending_r <= 1'b1;
            pair_done_r  <= 1'b0;
          end
        end
        default: begin
          state_r      <= ST_IDLE;
          lo_pending_r <= 1'b0;
          pair_done_r  <= 1'b0;
        end
      endcase
    end
  end

  assign sp         = sp_r;
  assign lo_pending = lo_pending_r;
  assign pair_done  = pair_done_r;
  assign ctl_err    = ctl_err_r;

endmodule

// File: doc/sm83_reg_sp_in.md
Name: sm83_reg_sp_in

Overview:
- Input/load side of the SM83 stack pointer register. It is the counterpart of the SP output bus drivers.
- Captures SP bytes from the precharged internal data bus. Loads the full 16-bit SP from the IDU result. Applies push/pop increments and decrements.
- Holds the SP value that the output drivers place on the address and data buses.
- Tracks split low/high byte loads for LD SP,nn and pair-load completion.

Parameters:
- RESET_VAL, 16'h0000, SP value forced while reset is high.
- L_sp, 60, load capacitance per sp output bit in timing-model units. Sets the clk-to-sp rise/fall delay through the package Elmore helpers.
- T_setup_ns, 0.5, bus/idu setup window before the clk rising edge. Used only by the timing checks.

Ports:
- clk  input  1  core clock; all state changes on the rising edge.
- reset  input  1  asynchronous, active-high reset.
- bus  input  8  internal data bus, precharged high. Any z or x bit samples as 1.
- idu  input  16  IDU adder result, for LD SP,HL and ADD SP,e writeback.
- ld_lo  input  1  load sp[7:0] from bus.
- ld_hi  input  1  load sp[15:8] from bus.
- ld_idu  input  1  load sp[15:0] from idu.
- inc  input  1  sp <= sp + 1 (pop).
- dec  input  1  sp <= sp - 1 (push).
- sp  output  16  current stack pointer.
- lo_pending  output  1  low byte loaded, high byte not yet loaded.
- pair_done  output  1  one-cycle pulse: a full 16-bit byte-pair load has completed.
- ctl_err  output  1  sticky flag: illegal control combination seen.

Behaviour:
- Reset, asynchronous, takes effect immediately:
  - sp = RESET_VAL, lo_pending = 0, pair_done = 0, ctl_err = 0, FSM = IDLE.
  - Reset asserted mid-operation discards any pending low byte.
  - Release is sampled at the next clk edge. The first edge with reset low may perform a load.
- Per-edge priority: ld_idu > byte loads (ld_lo/ld_hi) > inc/dec > hold.
  - ld_idu: sp <= idu. Concurrent ld_lo/ld_hi/inc/dec are ignored, and ctl_err is set if any of them is high.
  - ld_lo: sp[7:0] <= bus.
  - ld_hi: sp[15:8] <= bus.
  - ld_lo and ld_hi together: both bytes come from the same bus value in the same cycle.
  - Byte load together with inc or dec: the byte load wins, inc/dec is dropped, ctl_err is set.
  - inc and dec together: sp holds, ctl_err is set.
- Arithmetic is modulo 2^16. inc at 16'hFFFF gives 16'h0000. dec at 16'h0000 gives 16'hFFFF. Carry propagates across the byte boundary (16'h00FF + 1 = 16'h0100).
- Latency: sp reflects a load or inc/dec after the same rising edge, plus the clk-to-q delay derived from L_sp. No combinational path from any input to sp.
- Pair FSM, states IDLE and LO_HELD:
  - IDLE, ld_lo only -> LO_HELD.
  - IDLE, ld_hi only -> IDLE, no pulse.
  - IDLE, ld_lo and ld_hi -> IDLE, pair_done = 1 for one cycle.
  - LO_HELD, ld_hi -> IDLE, pair_done = 1 for one cycle.
  - LO_HELD, ld_lo -> LO_HELD; low byte overwritten.
  - LO_HELD, ld_idu, inc or dec -> IDLE, no pulse (abort). The operation itself still executes.
  - LO_HELD, no control -> LO_HELD indefinitely.
  - lo_pending = (state == LO_HELD), registered.
- pair_done is registered, high for exactly the cycle after the completing edge, and never high two cycles in a row unless two pair completions occur back to back.
- ctl_err stays set until reset.

Test Plan:
- Reset: assert reset asynchronously mid-cycle with sp = 16'h1234 -> sp = 0000, lo_pending = 0, ctl_err = 0 before the next edge.
- Split load: ld_lo with bus = 8'hFE, idle 3 cycles, then ld_hi with bus = 8'hFF -> lo_pending = 1 for 4 cycles, sp = FFFE, pair_done pulses once.
- Wrap: sp = FFFF, inc -> 0000. Then dec -> FFFF. sp = 00FF, inc -> 0100.
- Priority: ld_idu with idu = C000 plus inc in the same cycle -> sp = C000, ctl_err = 1. inc and dec together at sp = 8000 -> sp stays 8000.
- Abort: ld_lo with bus = 8'h34 (sp = xx34, LO_HELD), then dec -> sp decremented, FSM back to IDLE, no pair_done. A following ld_hi gives no pulse.
- Precharge: bus driven all z with ld_hi, sp = 0000 -> sp = FF00.
